// File: rtl/rf_dump.sv
// Register-file debug readout: walks a (possibly wrapping) address range through
// one read port and streams {addr, data} words over a valid/ready handshake.
module rf_dump #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, SEND} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_nxt;
  logic [ADDR_W-1:0] last_q, last_nxt;
  logic [ADDR_W-1:0] oaddr_nxt;
  logic [DATA_W-1:0] odata_nxt;
  logic              ovld_nxt, done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_nxt;
      last_q    <= last_nxt;
      out_valid <= ovld_nxt;
      out_data  <= odata_nxt;
      out_addr  <= oaddr_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_addr;
    last_nxt  = last_q;
    ovld_nxt  = out_valid;
    odata_nxt = out_data;
    oaddr_nxt = out_addr;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          last_nxt  = last_addr;
          cur_nxt   = first_addr;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          ovld_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          // R0 storage is never written and may hold garbage; it reads as zero
          odata_nxt = (cur_addr == '0) ? '0 : rf_rdata;
          oaddr_nxt = cur_addr;
          ovld_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          ovld_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (out_valid && out_ready) begin
          ovld_nxt = 1'b0;
          if (cur_addr == last_q) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cur_nxt   = cur_addr + ADDR_ONE;
            state_nxt = ISSUE;
          end
        end
      end
      default: begin
        ovld_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign rf_r_addr = cur_addr;

endmodule

// File: tb/tb_rf_dump.sv
// Directed bench for rf_dump with a negedge-read register file model.
module tb_rf_dump;
  logic        clk, rst_n, start, abort, out_ready;
  logic [3:0]  first_addr, last_addr, rf_r_addr, out_addr;
  logic [15:0] rf_rdata, out_data;
  logic        out_valid, busy, done;

  logic [15:0] mem [16];
  int checks = 0, errors = 0;
  int nhs;
  logic seen_done;
  logic [3:0]  hs_a [8];
  logic [15:0] hs_d [8];

  rf_dump #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr), .rf_r_addr(rf_r_addr),
    .rf_rdata(rf_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) rf_rdata <= mem[rf_r_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until done or a cycle budget; records every handshake seen.
  task automatic collect(input int budget, input int inj_at);
    nhs = 0;
    seen_done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (i == inj_at) begin
        start = 1'b1; first_addr = 4'd10; last_addr = 4'd12;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (out_valid && out_ready && nhs < 8) begin
        hs_a[nhs] = out_addr;
        hs_d[nhs] = out_data;
        nhs++;
      end
    end
    start = 1'b0;
    chk("collect_done_seen", {31'd0, seen_done}, 32'd1);
  endtask

  task automatic go(input logic [3:0] f, input logic [3:0] l);
    first_addr = f; last_addr = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'hxxxx;
    mem[1] = 16'h1111; mem[2] = 16'h2222; mem[3] = 16'h3333;
    mem[5] = 16'hBEEF; mem[14] = 16'hE0E0; mem[15] = 16'hF0F0;
    start = 0; abort = 0; out_ready = 0; first_addr = 0; last_addr = 0;
    rst_n = 0;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_outs", {12'd0, out_data, out_addr}, 32'd0);
    chk("rst_raddr", {28'd0, rf_r_addr}, 32'd0);
    rst_n = 1;
    tick();

    // 1..3, ready held high: words on cycles 2,4,6, done cycle 7
    out_ready = 1;
    go(4'd1, 4'd3);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_valid", {31'd0, out_valid}, 32'd0);
    chk("c1_raddr", {28'd0, rf_r_addr}, 32'd1);
    tick();
    chk("c2_word", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'h1111, 4'd1});
    tick();
    chk("c3_valid", {30'd0, out_valid, busy}, 32'd1);
    tick();
    chk("c4_word", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'h2222, 4'd2});
    tick();
    tick();
    chk("c6_word", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'h3333, 4'd3});
    chk("c6_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("c7_done", {29'd0, done, busy, out_valid}, 32'd4);
    tick();
    chk("c8_done_low", {31'd0, done}, 32'd0);

    // wrap 14..1 with R0 forced to zero
    go(4'd14, 4'd1);
    collect(30, -1);
    chk("wrap_count", 32'(nhs), 32'd4);
    chk("wrap_addrs", {16'd0, hs_a[0], hs_a[1], hs_a[2], hs_a[3]}, 32'h0000EF01);
    chk("wrap_d0", {16'd0, hs_d[0]}, 32'h0000E0E0);
    chk("wrap_d1", {16'd0, hs_d[1]}, 32'h0000F0F0);
    chk("wrap_r0_zero", {16'd0, hs_d[2]}, 32'h00000000);
    chk("wrap_d3", {16'd0, hs_d[3]}, 32'h00001111);
    tick();

    // single word 5 with 3-cycle stall
    out_ready = 0;
    go(4'd5, 4'd5);
    tick();
    chk("st_first", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'hBEEF, 4'd5});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'hBEEF, 4'd5});
    end
    out_ready = 1;
    tick();
    chk("st_done", {30'd0, done, out_valid}, 32'd2);
    tick();
    chk("st_done_once", {30'd0, done, busy}, 32'd0);

    // abort in SEND of second word of 1..8
    go(4'd1, 4'd8);
    tick();
    tick();
    tick();
    chk("ab_pre", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'h2222, 4'd2});
    abort = 1; out_ready = 0;
    tick();
    abort = 0; out_ready = 1;
    chk("ab_post", {29'd0, out_valid, busy, done}, 32'd0);
    tick();
    chk("ab_no_done", {30'd0, done, busy}, 32'd0);
    go(4'd8, 4'd8);
    tick();
    chk("ab_restart", {11'd0, out_valid, out_data, out_addr}, {11'd0, 1'b1, 16'hA008, 4'd8});
    tick();
    chk("ab_restart_done", {31'd0, done}, 32'd1);

    // start mid-dump is ignored
    go(4'd1, 4'd3);
    collect(30, 2);
    chk("ign_count", 32'(nhs), 32'd3);
    chk("ign_addrs", {20'd0, hs_a[0], hs_a[1], hs_a[2]}, 32'h00000123);
    chk("ign_d2", {16'd0, hs_d[2]}, 32'h00003333);
    tick();

    // async reset mid-ISSUE
    go(4'd1, 4'd3);
    chk("rs_issue", {31'd0, busy}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rs_async", {10'd0, out_valid, busy, done, out_data, out_addr, rf_r_addr}
        & 32'h3FFFFFFF, 32'd0);
    #3 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rs_quiet", {30'd0, out_valid, busy}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_dump.md
# rf_dump

Debug readout engine for the register file. On a start request it walks a contiguous, optionally wrapping, range of register addresses through one read port of the register file and streams each 16-bit value, tagged with its address, to a debug consumer over a valid/ready handshake. It sits beside the register file next to the core's normal read ports. It is muxed onto a read-address port only while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, default 4: register address width (16 registers).
- `DATA_W`, default 16: register data width.

Ports:
- `clk`  in  1  — single clock. The register file samples `rf_r_addr` and updates `rf_rdata` on the negedge of this clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — begin a dump. Sampled only in IDLE.
- `abort`  in  1  — cancel an in-progress dump.
- `first_addr`  in  ADDR_W  — first register to read. Sampled with `start`.
- `last_addr`  in  ADDR_W  — last register to read. Sampled with `start`.
- `rf_r_addr`  out  ADDR_W  — read address to the register file.
- `rf_rdata`  in  DATA_W  — read data from the register file.
- `out_valid`  out  1  — `out_data` and `out_addr` hold a word.
- `out_ready`  in  1  — consumer accepts the word.
- `out_data`  out  DATA_W  — register value.
- `out_addr`  out  ADDR_W  — register address of `out_data`.
- `busy`  out  1  — a dump is in progress.
- `done`  out  1  — one-cycle pulse after the last word is accepted.

## Operation
The block is a three-state FSM: IDLE, ISSUE, SEND.

IDLE:
- `busy`=0.
- If `start`=1: latch `last_addr`, set `cur_addr`←`first_addr`, set `busy`←1, go to ISSUE.

ISSUE:
- `rf_r_addr` is the registered `cur_addr`. It is stable for the whole cycle, so the register file captures it at the mid-cycle negedge.
- At the next posedge: `out_data`←`rf_rdata`, `out_addr`←`cur_addr`, `out_valid`←1, go to SEND.
- Exception: if `cur_addr`==0, `out_data`←16'h0000 regardless of `rf_rdata`. R0 is hardwired zero and its storage is never written.

SEND:
- Hold `out_valid`, `out_data` and `out_addr` stable until `out_valid`&&`out_ready` at a posedge.
- On that handshake, if `cur_addr`==last (latched): `out_valid`←0, `busy`←0, `done`←1 for one cycle, go to IDLE.
- Otherwise: `cur_addr`←`cur_addr`+1 mod 2^ADDR_W, `out_valid`←0, go to ISSUE.

Range and wrap rules:
- Word count = ((last − first) mod 16) + 1.
- first==last reads exactly one register.
- first>last wraps through 15→0. For example, first=14, last=1 reads 14, 15, 0, 1.

Abort and start rules:
- `abort`=1 at any posedge outside IDLE: go to IDLE, `out_valid`←0, `busy`←0, no `done` pulse. Abort has priority over a simultaneous handshake.
- `abort` in IDLE has no effect.
- `start` while busy is ignored. Inputs latched at the original start are unaffected.
- `start` and `abort` together in IDLE: the start is taken.

Reset:
- Asynchronous reset at any time, including mid-dump, forces IDLE with `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `rf_r_addr`=0.
- No word is emitted after reset until a new `start`.

## Timing
- Posedge-triggered flops only. The block relies on the register file's negedge read: an address registered at posedge N yields valid `rf_rdata` before posedge N+1.
- `start` sampled at posedge 0 → ISSUE during cycle 1 → `out_valid`=1 from cycle 2.
- First-word latency is 2 cycles.
- Throughput is at most 1 word per 2 cycles, because an ISSUE cycle separates consecutive words.
- `done` is asserted in the cycle after the final handshake. `busy` falls in that same cycle.
- A new `start` is accepted at the posedge that ends the `done` cycle.
- `out_valid` never drops without a handshake, except on abort or reset.
- `out_data` and `out_addr` change only at the ISSUE→SEND edge.

## Test plan
- Regfile preloaded with R1=16'h1111, R2=16'h2222, R3=16'h3333; start with first=1, last=3, `out_ready` held 1 → words (1,1111), (2,2222), (3,3333) on cycles 2, 4, 6; `done` pulses in cycle 7; `busy` high in cycles 1–6.
- first=14, last=1, R14=16'hE0E0, R15=16'hF0F0, R0 storage contains X → addresses 14, 15, 0, 1 in order; the R0 word is exactly 16'h0000; exactly 4 handshakes.
- first=last=5, R5=16'hBEEF, `out_ready` low for 3 cycles then high → `out_valid` and data 16'hBEEF stable throughout the stall; one handshake; `done` pulses once.
- Abort asserted in SEND of the second word of a 1..8 dump → `out_valid` and `busy` fall next cycle; no `done`; a subsequent start with first=8, last=8 works normally.
- `start` pulsed mid-dump with different addresses → ignored; the original range completes unchanged.
- `rst_n` asserted asynchronously mid-ISSUE → all outputs 0 immediately; no words emitted until a new `start`.
